// File: rtl/rs_pkg.sv
// Shared types for the multi-wakeup reservation station.
// Holds ALU_FUNC (sys_defs), RS entry and CDB port structs, CDB match helper.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

package sys_defs;
  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } ALU_FUNC;
endpackage

package rs_pkg;
  import sys_defs::*;

  localparam int RS_TAG_LEN  = `ROB_TAG_LEN;
  localparam int RS_DATA_LEN = `XLEN;

  typedef logic [RS_TAG_LEN-1:0]  tag_t;
  typedef logic [RS_DATA_LEN-1:0] data_t;

  typedef struct packed {
    ALU_FUNC func;
    tag_t    t1;
    tag_t    t2;
    tag_t    dst;
    logic    rdy1;
    logic    rdy2;
    data_t   v1;
    data_t   v2;
    data_t   pc;
    data_t   imm;
    logic    valid;
  } rs_entry_t;

  typedef struct packed {
    logic  valid;
    tag_t  tag;
    data_t value;
  } cdb_t;

  typedef struct packed {
    logic  hit;
    data_t value;
  } cdb_hit_t;

  function automatic cdb_hit_t cdb_match(
    input cdb_t p,
    input tag_t t
  );
    cdb_hit_t r;
    r.hit   = p.valid && (p.tag == t);
    r.value = p.value;
    return r;
  endfunction
endpackage

// File: rtl/rs_multiwake_if.sv
// Dispatch / CDB / issue bundle of the reservation station.
// master: dispatch+CDB+FU side; slave: the reservation station.
interface rs_multiwake_if #(
  parameter int NUM_CDB  = 2,
  parameter int TAG_LEN  = rs_pkg::RS_TAG_LEN,
  parameter int DATA_LEN = rs_pkg::RS_DATA_LEN
);
  import sys_defs::*;

  logic                        disp_valid;
  logic                        disp_ready;
  ALU_FUNC                     disp_func;
  logic [TAG_LEN-1:0]          disp_t1;
  logic [TAG_LEN-1:0]          disp_t2;
  logic [TAG_LEN-1:0]          disp_dst;
  logic                        disp_rdy1;
  logic                        disp_rdy2;
  logic [DATA_LEN-1:0]         disp_v1;
  logic [DATA_LEN-1:0]         disp_v2;
  logic [DATA_LEN-1:0]         disp_pc;
  logic [DATA_LEN-1:0]         disp_imm;

  logic [NUM_CDB-1:0]          cdb_valid;
  logic [NUM_CDB*TAG_LEN-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_LEN-1:0] cdb_value;

  logic                        iss_valid;
  logic                        iss_ready;
  ALU_FUNC                     iss_func;
  logic [DATA_LEN-1:0]         iss_v1;
  logic [DATA_LEN-1:0]         iss_v2;
  logic [DATA_LEN-1:0]         iss_pc;
  logic [DATA_LEN-1:0]         iss_imm;
  logic [TAG_LEN-1:0]          iss_dst;

  modport master (
    output disp_valid, disp_func,
    output disp_t1, disp_t2, disp_dst,
    output disp_rdy1, disp_rdy2,
    output disp_v1, disp_v2,
    output disp_pc, disp_imm,
    output cdb_valid, cdb_tag, cdb_value,
    output iss_ready,
    input  disp_ready, iss_valid,
    input  iss_func, iss_v1, iss_v2,
    input  iss_pc, iss_imm, iss_dst
  );

  modport slave (
    input  disp_valid, disp_func,
    input  disp_t1, disp_t2, disp_dst,
    input  disp_rdy1, disp_rdy2,
    input  disp_v1, disp_v2,
    input  disp_pc, disp_imm,
    input  cdb_valid, cdb_tag, cdb_value,
    input  iss_ready,
    output disp_ready, iss_valid,
    output iss_func, iss_v1, iss_v2,
    output iss_pc, iss_imm, iss_dst
  );
endinterface

// File: rtl/rs_age_matrix.sv
// Age matrix: older[i][j]=1 means entry j was allocated before entry i.
// Ports: alloc/free one-hot, valid mask, req vector in; oldest grant out.
module rs_age_matrix #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic [N-1:0] valid,
  input  logic [N-1:0] alloc,
  input  logic [N-1:0] free,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  logic [N-1:0] older [N];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++)
        older[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < N; i++)
        older[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        // new entry is younger than every survivor
        if (alloc[i])
          older[i] <= valid & ~free;
        else if (free[i])
          older[i] <= '0;
        else
          older[i] <= older[i] & ~free;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      gnt[i] = req[i] && ((req & older[i]) == '0);
  end
endmodule

// File: rtl/rs_multiwake.sv
// Reservation station: NUM_ENTRIES slots, NUM_CDB wakeup ports, oldest-first.
// Ports: clk, reset_n, flush, rs (slave bundle), occupancy; RS_PERF_CNT_EN adds perf counters.
module rs_multiwake
  import sys_defs::*;
  import rs_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_CDB     = 2,
  parameter int TAG_LEN     = RS_TAG_LEN,
  parameter int DATA_LEN    = RS_DATA_LEN
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  rs_multiwake_if.slave                rs,
`ifdef RS_PERF_CNT_EN
  output logic [31:0]                  perf_full_cycles,
  output logic [31:0]                  perf_ready_stall_cycles,
`endif
  output logic [$clog2(NUM_ENTRIES):0] occupancy
);
  localparam int IW = $clog2(NUM_ENTRIES);
  localparam int OW = IW + 1;

  rs_entry_t ent   [NUM_ENTRIES];
  rs_entry_t ent_n [NUM_ENTRIES];
  cdb_t      cdb   [NUM_CDB];
  data_t     bv1   [NUM_ENTRIES];
  data_t     bv2   [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] hit1;
  logic [NUM_ENTRIES-1:0] hit2;
  logic [NUM_ENTRIES-1:0] req;
  logic [NUM_ENTRIES-1:0] vmask;
  logic [NUM_ENTRIES-1:0] slot;
  logic [NUM_ENTRIES-1:0] alloc;
  logic [NUM_ENTRIES-1:0] free;
  logic [NUM_ENTRIES-1:0] gnt;

  logic     disp_ready;
  logic     disp_fire;
  logic     iss_valid;
  logic     iss_fire;
  logic     dh1;
  logic     dh2;
  data_t    dv1;
  data_t    dv2;
  cdb_hit_t m1;
  cdb_hit_t m2;
  cdb_hit_t d1;
  cdb_hit_t d2;

  always_comb begin
    for (int p = 0; p < NUM_CDB; p++) begin
      cdb[p].valid = rs.cdb_valid[p];
      cdb[p].tag   = rs.cdb_tag[p*TAG_LEN +: TAG_LEN];
      cdb[p].value = rs.cdb_value[p*DATA_LEN +: DATA_LEN];
    end
  end

  // descending scan: lowest port index lands last and wins
  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      hit1[i] = 1'b0;
      hit2[i] = 1'b0;
      bv1[i]  = ent[i].v1;
      bv2[i]  = ent[i].v2;
      for (int p = NUM_CDB - 1; p >= 0; p--) begin
        m1 = cdb_match(cdb[p], ent[i].t1);
        m2 = cdb_match(cdb[p], ent[i].t2);
        if (ent[i].valid && !ent[i].rdy1 && m1.hit) begin
          hit1[i] = 1'b1;
          bv1[i]  = m1.value;
        end
        if (ent[i].valid && !ent[i].rdy2 && m2.hit) begin
          hit2[i] = 1'b1;
          bv2[i]  = m2.value;
        end
      end
      vmask[i] = ent[i].valid;
      req[i]   = ent[i].valid
               && (ent[i].rdy1 || hit1[i])
               && (ent[i].rdy2 || hit2[i]);
    end
  end

  always_comb begin
    d1  = '0;
    d2  = '0;
    dh1 = 1'b0;
    dh2 = 1'b0;
    dv1 = rs.disp_v1;
    dv2 = rs.disp_v2;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      d1 = cdb_match(cdb[p], rs.disp_t1);
      d2 = cdb_match(cdb[p], rs.disp_t2);
      if (!rs.disp_rdy1 && d1.hit) begin
        dh1 = 1'b1;
        dv1 = d1.value;
      end
      if (!rs.disp_rdy2 && d2.hit) begin
        dh2 = 1'b1;
        dv2 = d2.value;
      end
    end
  end

  always_comb begin
    slot = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!ent[i].valid) begin
        slot    = '0;
        slot[i] = 1'b1;
      end
    end
  end

  assign disp_ready    = occupancy != OW'(NUM_ENTRIES);
  assign disp_fire     = rs.disp_valid && disp_ready;
  assign iss_valid     = |req;
  assign iss_fire      = iss_valid && rs.iss_ready;
  assign alloc         = disp_fire ? slot : '0;
  assign free          = iss_fire ? gnt : '0;
  assign rs.disp_ready = disp_ready;
  assign rs.iss_valid  = iss_valid;

  rs_age_matrix #(
    .N(NUM_ENTRIES)
  ) u_age (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (flush),
    .valid  (vmask),
    .alloc  (alloc),
    .free   (free),
    .req    (req),
    .gnt    (gnt)
  );

  always_comb begin
    rs.iss_func = ALU_ADD;
    rs.iss_v1   = '0;
    rs.iss_v2   = '0;
    rs.iss_pc   = '0;
    rs.iss_imm  = '0;
    rs.iss_dst  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (gnt[i]) begin
        rs.iss_func = ent[i].func;
        rs.iss_v1   = bv1[i];
        rs.iss_v2   = bv2[i];
        rs.iss_pc   = ent[i].pc;
        rs.iss_imm  = ent[i].imm;
        rs.iss_dst  = ent[i].dst;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ent_n[i] = ent[i];
      if (hit1[i]) begin
        ent_n[i].rdy1 = 1'b1;
        ent_n[i].v1   = bv1[i];
      end
      if (hit2[i]) begin
        ent_n[i].rdy2 = 1'b1;
        ent_n[i].v2   = bv2[i];
      end
      if (free[i])
        ent_n[i].valid = 1'b0;
      if (alloc[i]) begin
        ent_n[i].func  = rs.disp_func;
        ent_n[i].t1    = rs.disp_t1;
        ent_n[i].t2    = rs.disp_t2;
        ent_n[i].dst   = rs.disp_dst;
        ent_n[i].rdy1  = rs.disp_rdy1 || dh1;
        ent_n[i].rdy2  = rs.disp_rdy2 || dh2;
        ent_n[i].v1    = dv1;
        ent_n[i].v2    = dv2;
        ent_n[i].pc    = rs.disp_pc;
        ent_n[i].imm   = rs.disp_imm;
        ent_n[i].valid = 1'b1;
      end
      if (flush)
        ent_n[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++)
        ent[i] <= '0;
      occupancy <= '0;
    end else begin
      ent <= ent_n;
      if (flush)
        occupancy <= '0;
      else
        occupancy <= occupancy
                   + {{IW{1'b0}}, disp_fire}
                   - {{IW{1'b0}}, iss_fire};
    end
  end

`ifdef RS_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_full_cycles        <= '0;
      perf_ready_stall_cycles <= '0;
    end else begin
      if (rs.disp_valid && !disp_ready
          && perf_full_cycles != '1)
        perf_full_cycles <= perf_full_cycles + 32'd1;
      if (iss_valid && !rs.iss_ready
          && perf_ready_stall_cycles != '1)
        perf_ready_stall_cycles <= perf_ready_stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rs_multiwake.sv
// Bench for rs_multiwake: vector table, directed corner sequences,
// then random traffic against a queue-based oldest-first model.
module tb_rs_multiwake;
  import sys_defs::*;

  localparam int NE = 8;
  localparam int NC = 2;
  localparam int TL = rs_pkg::RS_TAG_LEN;
  localparam int DL = rs_pkg::RS_DATA_LEN;

  logic clk;
  logic reset_n;
  logic flush;
  logic [$clog2(NE):0] occupancy;
`ifdef RS_PERF_CNT_EN
  logic [31:0] perf_full;
  logic [31:0] perf_stall;
`endif

  int tests;
  int fails;

  rs_multiwake_if #(
    .NUM_CDB(NC), .TAG_LEN(TL), .DATA_LEN(DL)
  ) bus ();

  rs_multiwake #(
    .NUM_ENTRIES(NE), .NUM_CDB(NC),
    .TAG_LEN(TL), .DATA_LEN(DL)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .flush                  (flush),
    .rs                     (bus),
`ifdef RS_PERF_CNT_EN
    .perf_full_cycles       (perf_full),
    .perf_ready_stall_cycles(perf_stall),
`endif
    .occupancy              (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          dv;
    logic [TL-1:0] dst;
    logic          ir;
    logic          exp_dr;
    int            exp_occ;
    logic          exp_iv;
    logic [TL-1:0] exp_dst;
  } vec_t;

  typedef struct {
    ALU_FUNC       func;
    logic [TL-1:0] t1;
    logic [TL-1:0] t2;
    logic [TL-1:0] dst;
    bit            r1;
    bit            r2;
    logic [DL-1:0] v1;
    logic [DL-1:0] v2;
    logic [DL-1:0] pc;
    logic [DL-1:0] imm;
  } ment_t;

  vec_t  vt [17];
  ment_t mq [$];
  ment_t nm;
  int    sel;
  bit    ok1, ok2, fi, fd;
  logic [DL-1:0] w, e1, e2, ev1, ev2;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    bus.disp_func  = ALU_ADD;
    bus.disp_t1    = '0;
    bus.disp_t2    = '0;
    bus.disp_dst   = '0;
    bus.disp_rdy1  = 1'b1;
    bus.disp_rdy2  = 1'b1;
    bus.disp_v1    = '0;
    bus.disp_v2    = '0;
    bus.disp_pc    = '0;
    bus.disp_imm   = '0;
    bus.cdb_valid  = '0;
    bus.cdb_tag    = '0;
    bus.cdb_value  = '0;
    bus.iss_ready  = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic disp(input logic [TL-1:0] dst,
                      input logic [TL-1:0] t1,
                      input logic r1);
    bus.disp_valid = 1'b1;
    bus.disp_func  = ALU_SUB;
    bus.disp_dst   = dst;
    bus.disp_t1    = t1;
    bus.disp_rdy1  = r1;
    bus.disp_t2    = '0;
    bus.disp_rdy2  = 1'b1;
    bus.disp_v1    = r1 ? DL'(32'h100 + dst) : '0;
    bus.disp_v2    = DL'(32'h200 + dst);
    bus.disp_pc    = DL'(32'h1000 + 4 * dst);
    bus.disp_imm   = DL'(dst);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  function automatic bit look(input logic [TL-1:0] t,
                              output logic [DL-1:0] v);
    v = '0;
    for (int p = 0; p < NC; p++) begin
      if (bus.cdb_valid[p] && bus.cdb_tag[p*TL +: TL] == t) begin
        v = bus.cdb_value[p*DL +: DL];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_disp_ready", bus.disp_ready, 1);
    check("rst_iss_valid", bus.iss_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_iss_dst", bus.iss_dst, 0);
    reset_n = 1'b1;

    for (int r = 0; r < 17; r++) begin
      if (r < 8) begin
        vt[r] = '{1'b1, TL'(r + 1), 1'b0, 1'b1,
                  r, (r > 0), TL'(1)};
      end else if (r < 16) begin
        vt[r] = '{1'b0, '0, 1'b1, (r != 8),
                  16 - r, 1'b1, TL'(r - 7)};
      end else begin
        vt[r] = '{1'b0, '0, 1'b0, 1'b1,
                  0, 1'b0, '0};
      end
    end

    for (int r = 0; r < 17; r++) begin
      idle();
      if (vt[r].dv) disp(vt[r].dst, '0, 1'b1);
      bus.iss_ready = vt[r].ir;
      mid();
      check("tbl_disp_ready", bus.disp_ready, vt[r].exp_dr);
      check("tbl_occ", occupancy, vt[r].exp_occ);
      check("tbl_iss_valid", bus.iss_valid, vt[r].exp_iv);
      if (vt[r].exp_iv)
        check("tbl_iss_dst", bus.iss_dst, vt[r].exp_dst);
      tick();
    end

    idle();
    disp(TL'(10), TL'(5), 1'b0);
    tick();
    idle();
    disp(TL'(11), TL'(6), 1'b0);
    mid();
    check("wait_iss_valid", bus.iss_valid, 0);
    tick();
    idle();
    bus.cdb_valid = 2'b11;
    bus.cdb_tag   = {TL'(6), TL'(5)};
    bus.cdb_value = {DL'(32'h66), DL'(32'h55)};
    mid();
    check("byp_iss_valid", bus.iss_valid, 1);
    check("byp_iss_dst", bus.iss_dst, 10);
    check("byp_iss_v1", bus.iss_v1, 32'h55);
    tick();
    idle();
    bus.iss_ready = 1'b1;
    mid();
    check("wakeA_dst", bus.iss_dst, 10);
    check("wakeA_v1", bus.iss_v1, 32'h55);
    tick();
    idle();
    bus.iss_ready = 1'b1;
    mid();
    check("wakeB_dst", bus.iss_dst, 11);
    check("wakeB_v1", bus.iss_v1, 32'h66);
    tick();
    idle();
    mid();
    check("wake_empty", occupancy, 0);
    tick();

    idle();
    disp(TL'(12), TL'(9), 1'b0);
    bus.cdb_valid = 2'b10;
    bus.cdb_tag   = {TL'(9), TL'(0)};
    bus.cdb_value = {DL'(32'hAB), DL'(32'h0)};
    mid();
    check("dcap_iss_valid", bus.iss_valid, 0);
    tick();
    idle();
    bus.iss_ready = 1'b1;
    mid();
    check("dcap_iss_valid2", bus.iss_valid, 1);
    check("dcap_iss_v1", bus.iss_v1, 32'hAB);
    check("dcap_iss_dst", bus.iss_dst, 12);
    tick();

    for (int k = 0; k < 8; k++) begin
      idle();
      disp(TL'(20 + k), '0, 1'b1);
      tick();
    end
    idle();
    disp(TL'(28), '0, 1'b1);
    bus.iss_ready = 1'b1;
    mid();
    check("full_disp_ready", bus.disp_ready, 0);
    check("full_iss_dst", bus.iss_dst, 20);
    tick();
    idle();
    disp(TL'(28), '0, 1'b1);
    mid();
    check("full_occ7", occupancy, 7);
    check("full_disp_ready2", bus.disp_ready, 1);
    tick();
    idle();
    mid();
    check("full_occ8", occupancy, 8);
    check("full_disp_ready3", bus.disp_ready, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      idle();
      bus.iss_ready = 1'b1;
      mid();
      check("drain_dst", bus.iss_dst, 21 + k);
      tick();
    end
    idle();
    flush = 1'b1;
    disp(TL'(40), '0, 1'b1);
    mid();
    check("pre_flush_occ", occupancy, 5);
    tick();
    idle();
    mid();
    check("flush_occ", occupancy, 0);
    check("flush_iss_valid", bus.iss_valid, 0);
    check("flush_disp_ready", bus.disp_ready, 1);
    tick();
    idle();
    mid();
    check("flush_drop_occ", occupancy, 0);
    tick();

    idle();
    disp(TL'(50), '0, 1'b1);
    tick();
    idle();
    disp(TL'(51), '0, 1'b1);
    tick();
    idle();
    mid();
    check("prerst_iss_valid", bus.iss_valid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_iss_valid", bus.iss_valid, 0);
    check("arst_occ", occupancy, 0);
    check("arst_disp_ready", bus.disp_ready, 1);
    check("arst_iss_dst", bus.iss_dst, 0);
    check("arst_iss_v1", bus.iss_v1, 0);
    #1;
    reset_n = 1'b1;
    tick();

    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      idle();
      bus.disp_valid = ($urandom_range(0, 9) < 6);
      bus.disp_func  = ALU_FUNC'($urandom_range(0, 9));
      bus.disp_t1    = TL'($urandom_range(1, 7));
      bus.disp_t2    = TL'($urandom_range(1, 7));
      bus.disp_dst   = TL'($urandom_range(0, 63));
      bus.disp_rdy1  = 1'($urandom_range(0, 1));
      bus.disp_rdy2  = 1'($urandom_range(0, 1));
      bus.disp_v1    = DL'($urandom);
      bus.disp_v2    = DL'($urandom);
      bus.disp_pc    = DL'($urandom);
      bus.disp_imm   = DL'($urandom);
      for (int p = 0; p < NC; p++) begin
        bus.cdb_valid[p] = ($urandom_range(0, 9) < 4);
        bus.cdb_tag[p*TL +: TL] = TL'($urandom_range(1, 7));
        bus.cdb_value[p*DL +: DL] = DL'($urandom);
      end
      bus.iss_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 39) == 0);
      mid();

      sel = -1;
      ev1 = '0;
      ev2 = '0;
      for (int k = 0; k < mq.size(); k++) begin
        ok1 = mq[k].r1;
        e1  = mq[k].v1;
        if (!ok1 && look(mq[k].t1, w)) begin
          ok1 = 1'b1;
          e1  = w;
        end
        ok2 = mq[k].r2;
        e2  = mq[k].v2;
        if (!ok2 && look(mq[k].t2, w)) begin
          ok2 = 1'b1;
          e2  = w;
        end
        if (ok1 && ok2 && sel < 0) begin
          sel = k;
          ev1 = e1;
          ev2 = e2;
        end
      end

      check("rnd_iss_valid", bus.iss_valid, (sel >= 0));
      check("rnd_disp_ready", bus.disp_ready, (mq.size() != NE));
      check("rnd_occ", occupancy, mq.size());
      if (sel >= 0) begin
        check("rnd_iss_dst", bus.iss_dst, mq[sel].dst);
        check("rnd_iss_v1", bus.iss_v1, ev1);
        check("rnd_iss_v2", bus.iss_v2, ev2);
        check("rnd_iss_func", bus.iss_func, mq[sel].func);
        check("rnd_iss_pcimm",
              {bus.iss_pc, bus.iss_imm},
              {mq[sel].pc, mq[sel].imm});
      end

      fi = (sel >= 0) && bus.iss_ready;
      fd = bus.disp_valid && (mq.size() != NE);
      if (flush) begin
        mq.delete();
      end else begin
        if (fi) mq.delete(sel);
        foreach (mq[k]) begin
          if (!mq[k].r1 && look(mq[k].t1, w)) begin
            mq[k].r1 = 1'b1;
            mq[k].v1 = w;
          end
          if (!mq[k].r2 && look(mq[k].t2, w)) begin
            mq[k].r2 = 1'b1;
            mq[k].v2 = w;
          end
        end
        if (fd) begin
          nm.func = bus.disp_func;
          nm.t1   = bus.disp_t1;
          nm.t2   = bus.disp_t2;
          nm.dst  = bus.disp_dst;
          nm.r1   = bus.disp_rdy1;
          nm.r2   = bus.disp_rdy2;
          nm.v1   = bus.disp_v1;
          nm.v2   = bus.disp_v2;
          nm.pc   = bus.disp_pc;
          nm.imm  = bus.disp_imm;
          if (!nm.r1 && look(nm.t1, w)) begin
            nm.r1 = 1'b1;
            nm.v1 = w;
          end
          if (!nm.r2 && look(nm.t2, w)) begin
            nm.r2 = 1'b1;
            nm.v2 = w;
          end
          mq.push_back(nm);
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
